// File: rtl/mem_arbiter.sv
// Purpose: arbitrates one single-port memory between instruction fetch and data access.
// Latency: grant on the first IDLE edge, ack one edge after mem_ready; 2 cycles minimum, 3 per access back-to-back.
// Backpressure: mem_ready=0 holds the access indefinitely; stall freezes the pipeline while a request is open.
//
// Ports:
//   clk, reset                          clock, asynchronous active-high reset
//   if_req/if_addr -> if_ack/if_rdata   fetch request and registered result
//   dm_req/dm_we/dm_addr/dm_wdata       data request; dm_ack/dm_rdata registered result
//   mem_req/mem_we/mem_addr/mem_wdata   registered memory command, stable for the whole access
//   mem_rdata/mem_ready                 memory response
//   stall                               combinational: some request is open and not yet acked
module mem_arbiter #(
  parameter int MAX_DM_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ack,
  output logic [31:0] dm_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall
);

  localparam int SW = (MAX_DM_BURST < 1) ? 1 : $clog2(MAX_DM_BURST + 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

  state_t        state;
  logic [SW-1:0] dm_streak;

  logic if_elig;
  logic dm_elig;
  logic turnaround;
  logic streak_full;
  logic grant_dm;
  logic grant_if;

  // A requester whose ack is high is still holding the req it just had
  // serviced, so it must not be granted again off that same req.
  assign if_elig = if_req & ~if_ack;
  assign dm_elig = dm_req & ~dm_ack;

  // The IDLE cycle carrying an ack is a turnaround cycle: nothing is granted
  // in it, which gives every access the same 3-cycle slot and lets the data
  // streak count consecutive data accesses under continuous contention.
  assign turnaround  = if_ack | dm_ack;
  assign streak_full = (dm_streak == SW'(MAX_DM_BURST));

  // Data has priority unless it has already taken MAX_DM_BURST grants in a
  // row while a fetch was waiting.
  assign grant_dm = (state == IDLE) & ~turnaround & dm_elig & ~(if_elig & streak_full);
  assign grant_if = (state == IDLE) & ~turnaround & if_elig & ~grant_dm;

  assign stall = (if_req & ~if_ack) | (dm_req & ~dm_ack);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      dm_streak <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (state)
        IDLE: begin
          // mem_ready is deliberately not looked at here.
          if (grant_dm) begin
            state     <= BUSY_DM;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            // Only data grants that made a fetch wait extend the streak.
            if (if_req) begin
              if (!streak_full) dm_streak <= dm_streak + SW'(1);
            end else begin
              dm_streak <= '0;
            end
          end else if (grant_if) begin
            state     <= BUSY_IF;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            dm_streak <= '0;
          end
        end
        BUSY_IF: begin
          if (mem_ready) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            if_ack   <= 1'b1;
            if_rdata <= mem_rdata;
          end
        end
        BUSY_DM: begin
          if (mem_ready) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            dm_ack  <= 1'b1;
            // A store leaves the last load result in place.
            if (!mem_we) dm_rdata <= mem_rdata;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle table for the basic transactions,
// then hand-written sequences for contention, held requests and reset.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall;

  int n_vec;
  int n_miss;

  mem_arbiter #(.MAX_DM_BURST(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_ack    (dm_ack),
    .dm_rdata  (dm_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .stall     (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        e_mem_req;
    logic        e_mem_we;
    logic [31:0] e_mem_addr;
    logic [31:0] e_mem_wdata;
    logic        e_if_ack;
    logic        e_dm_ack;
    logic [31:0] e_if_rdata;
    logic [31:0] e_dm_rdata;
    logic        e_stall;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_miss);
    $fatal(1);
  end

  localparam logic [31:0] A = 32'h0050_0093;
  localparam logic [31:0] B = 32'hDEAD_BEEF;
  localparam logic [31:0] C = 32'hCAFE_F00D;

  initial begin
    byte exp_order [10];
    byte got_order [10];
    int  ng;
    int  cyc;
    logic prev_req;

    n_vec = 0;
    n_miss = 0;

    //            inputs: if_req if_addr dm_req dm_we dm_addr dm_wdata rdy rdata
    //            expect: mem_req we addr wdata if_ack dm_ack if_rdata dm_rdata stall
    // single fetch from 0x100
    tbl[0]  = '{1, 32'h100, 0, 0, 32'h0,  32'h0, 0, 32'h0,          0, 0, 32'h0,   32'h0, 0, 0, 32'h0, 32'h0, 1};
    tbl[1]  = '{1, 32'h100, 0, 0, 32'h0,  32'h0, 1, A,              1, 0, 32'h100, 32'h0, 0, 0, 32'h0, 32'h0, 1};
    tbl[2]  = '{1, 32'h100, 0, 0, 32'h0,  32'h0, 0, 32'h0,          0, 0, 32'h100, 32'h0, 1, 0, A,     32'h0, 0};
    // store 0xDEADBEEF to 0x40; memory returns junk which must not load
    tbl[3]  = '{0, 32'h100, 1, 1, 32'h40, B,     0, 32'h0,          0, 0, 32'h100, 32'h0, 0, 0, A,     32'h0, 1};
    tbl[4]  = '{0, 32'h100, 1, 1, 32'h40, B,     1, 32'h1234_5678,  1, 1, 32'h40,  B,     0, 0, A,     32'h0, 1};
    tbl[5]  = '{0, 32'h100, 1, 1, 32'h40, B,     0, 32'h0,          0, 1, 32'h40,  B,     0, 1, A,     32'h0, 0};
    // load from 0x40; mem_ready high while IDLE is ignored
    tbl[6]  = '{0, 32'h100, 1, 0, 32'h40, 32'h0, 1, 32'hBAD0_BAD0,  0, 1, 32'h40,  B,     0, 0, A,     32'h0, 1};
    tbl[7]  = '{0, 32'h100, 1, 0, 32'h40, 32'h0, 1, B,              1, 0, 32'h40,  32'h0, 0, 0, A,     32'h0, 1};
    tbl[8]  = '{0, 32'h100, 1, 0, 32'h40, 32'h0, 0, 32'h0,          0, 0, 32'h40,  32'h0, 0, 1, A,     B,     0};
    tbl[9]  = '{0, 32'h100, 0, 0, 32'h40, 32'h0, 0, 32'h0,          0, 0, 32'h40,  32'h0, 0, 0, A,     B,     0};
    // fetch from 0x200 with 5 wait states; if_addr changes mid-access
    tbl[10] = '{1, 32'h200, 0, 0, 32'h40, 32'h0, 0, 32'h0,          0, 0, 32'h40,  32'h0, 0, 0, A,     B,     1};
    tbl[11] = '{1, 32'h300, 0, 0, 32'h40, 32'h0, 0, 32'h0,          1, 0, 32'h200, 32'h0, 0, 0, A,     B,     1};
    tbl[12] = '{1, 32'h300, 0, 0, 32'h40, 32'h0, 0, 32'h0,          1, 0, 32'h200, 32'h0, 0, 0, A,     B,     1};
    tbl[13] = '{1, 32'h300, 0, 0, 32'h40, 32'h0, 0, 32'h0,          1, 0, 32'h200, 32'h0, 0, 0, A,     B,     1};
    tbl[14] = '{1, 32'h300, 0, 0, 32'h40, 32'h0, 0, 32'h0,          1, 0, 32'h200, 32'h0, 0, 0, A,     B,     1};
    tbl[15] = '{1, 32'h300, 0, 0, 32'h40, 32'h0, 0, 32'h0,          1, 0, 32'h200, 32'h0, 0, 0, A,     B,     1};
    tbl[16] = '{1, 32'h300, 0, 0, 32'h40, 32'h0, 1, C,              1, 0, 32'h200, 32'h0, 0, 0, A,     B,     1};
    tbl[17] = '{1, 32'h300, 0, 0, 32'h40, 32'h0, 0, 32'h0,          0, 0, 32'h200, 32'h0, 1, 0, C,     B,     0};
    tbl[18] = '{0, 32'h300, 0, 0, 32'h40, 32'h0, 0, 32'h0,          0, 0, 32'h200, 32'h0, 0, 0, C,     B,     0};

    exp_order = '{"D", "D", "D", "D", "F", "D", "D", "D", "D", "F"};

    // ---------------- reset state ----------------
    reset = 1'b1;
    if_req = 0; if_addr = '0;
    dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
    mem_ready = 0; mem_rdata = '0;
    #1;
    chk("reset mem_req",   {31'b0, mem_req}, 32'h0);
    chk("reset mem_addr",  mem_addr,  32'h0);
    chk("reset if_rdata",  if_rdata,  32'h0);
    chk("reset dm_ack",    {31'b0, dm_ack},  32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // ---------------- table ----------------
    for (int i = 0; i < 19; i++) begin
      if_req    = tbl[i].if_req;
      if_addr   = tbl[i].if_addr;
      dm_req    = tbl[i].dm_req;
      dm_we     = tbl[i].dm_we;
      dm_addr   = tbl[i].dm_addr;
      dm_wdata  = tbl[i].dm_wdata;
      mem_ready = tbl[i].mem_ready;
      mem_rdata = tbl[i].mem_rdata;
      #1;
      chk($sformatf("r%0d mem_req", i),   {31'b0, mem_req}, {31'b0, tbl[i].e_mem_req});
      chk($sformatf("r%0d mem_we", i),    {31'b0, mem_we},  {31'b0, tbl[i].e_mem_we});
      chk($sformatf("r%0d mem_addr", i),  mem_addr,         tbl[i].e_mem_addr);
      chk($sformatf("r%0d mem_wdata", i), mem_wdata,        tbl[i].e_mem_wdata);
      chk($sformatf("r%0d if_ack", i),    {31'b0, if_ack},  {31'b0, tbl[i].e_if_ack});
      chk($sformatf("r%0d dm_ack", i),    {31'b0, dm_ack},  {31'b0, tbl[i].e_dm_ack});
      chk($sformatf("r%0d if_rdata", i),  if_rdata,         tbl[i].e_if_rdata);
      chk($sformatf("r%0d dm_rdata", i),  dm_rdata,         tbl[i].e_dm_rdata);
      chk($sformatf("r%0d stall", i),     {31'b0, stall},   {31'b0, tbl[i].e_stall});
      tick();
    end

    // ---------------- contention: both held, memory always ready ----------------
    if_req = 1; if_addr = 32'h1000;
    dm_req = 1; dm_we = 0; dm_addr = 32'h2000; dm_wdata = '0;
    mem_ready = 1; mem_rdata = '0;
    ng = 0;
    cyc = 0;
    prev_req = 1'b0;
    while (ng < 10 && cyc < 80) begin
      #1;
      if (mem_req && !prev_req) begin
        got_order[ng] = (mem_addr == 32'h2000) ? "D" : (mem_addr == 32'h1000) ? "F" : "?";
        ng++;
      end
      prev_req = mem_req;
      if (ng < 10) tick();
      cyc++;
    end
    chk("contention grant count", ng, 10);
    for (int k = 0; k < 10; k++) begin
      if (k < ng) chk($sformatf("contention grant %0d", k), {24'b0, got_order[k]}, {24'b0, exp_order[k]});
    end
    // the last fetch is already granted; dropping the req must not cancel it
    if_req = 0; dm_req = 0;
    tick();
    #1;
    chk("dropped-after-grant if_ack", {31'b0, if_ack}, 32'h1);
    chk("dropped-after-grant mem_req", {31'b0, mem_req}, 32'h0);
    tick();

    // ---------------- held dm_req in ack cycle with fetch waiting ----------------
    dm_req = 1; dm_we = 0; dm_addr = 32'h44; mem_ready = 0;
    tick();
    #1;
    chk("held data granted addr", mem_addr, 32'h44);
    if_req = 1; if_addr = 32'h500; mem_ready = 1; mem_rdata = 32'h1111_1111;
    tick();
    #1;
    chk("held dm_ack", {31'b0, dm_ack}, 32'h1);
    chk("held dm_rdata", dm_rdata, 32'h1111_1111);
    chk("held ack-cycle mem_req", {31'b0, mem_req}, 32'h0);
    mem_ready = 0;
    tick();
    dm_req = 0;
    #1;
    chk("held turnaround mem_req", {31'b0, mem_req}, 32'h0);
    tick();
    #1;
    chk("held next grant mem_req", {31'b0, mem_req}, 32'h1);
    chk("held next grant is fetch", mem_addr, 32'h500);
    chk("held next grant mem_we", {31'b0, mem_we}, 32'h0);
    mem_ready = 1; mem_rdata = 32'h2222_2222;
    tick();
    #1;
    chk("held if_ack", {31'b0, if_ack}, 32'h1);
    chk("held if_rdata", if_rdata, 32'h2222_2222);
    chk("held no second dm_ack", {31'b0, dm_ack}, 32'h0);
    if_req = 0; mem_ready = 0;
    tick();
    #1;
    chk("held idle mem_req", {31'b0, mem_req}, 32'h0);

    // ---------------- reset in the middle of a store ----------------
    dm_req = 1; dm_we = 1; dm_addr = 32'h80; dm_wdata = 32'h55AA_55AA; mem_ready = 0;
    tick();
    #1;
    chk("pre-reset mem_req", {31'b0, mem_req}, 32'h1);
    chk("pre-reset mem_we", {31'b0, mem_we}, 32'h1);
    mem_ready = 1;
    reset = 1;
    #1;
    chk("mid-op reset mem_req", {31'b0, mem_req}, 32'h0);
    chk("mid-op reset mem_we", {31'b0, mem_we}, 32'h0);
    chk("mid-op reset mem_addr", mem_addr, 32'h0);
    chk("mid-op reset mem_wdata", mem_wdata, 32'h0);
    chk("mid-op reset if_rdata", if_rdata, 32'h0);
    chk("mid-op reset dm_rdata", dm_rdata, 32'h0);
    tick();
    #1;
    chk("mid-op reset no dm_ack", {31'b0, dm_ack}, 32'h0);
    reset = 0;
    mem_ready = 0;
    tick();
    #1;
    chk("post-reset regrant mem_req", {31'b0, mem_req}, 32'h1);
    chk("post-reset regrant addr", mem_addr, 32'h80);
    mem_ready = 1;
    tick();
    #1;
    chk("post-reset dm_ack", {31'b0, dm_ack}, 32'h1);
    chk("post-reset store keeps dm_rdata", dm_rdata, 32'h0);
    dm_req = 0; mem_ready = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_DM_BURST, default 4, which sets the maximum number of consecutive data grants while a fetch is waiting.
REQ-002 clk  input  1  clock; all state updates on its rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 if_req  input  1  instruction-fetch read request, held until if_ack.
REQ-005 if_addr  input  32  fetch address.
REQ-006 if_ack  output  1  one-cycle pulse: fetch complete.
REQ-007 if_rdata  output  32  fetched word, registered, held until the next fetch completes.
REQ-008 dm_req  input  1  data-stage request (driven from the memory-stage pipeline register), held until dm_ack.
REQ-009 dm_we  input  1  1 = store, 0 = load.
REQ-010 dm_addr  input  32  data address.
REQ-011 dm_wdata  input  32  store data.
REQ-012 dm_ack  output  1  one-cycle pulse: data access complete.
REQ-013 dm_rdata  output  32  load data, registered, held until the next load completes.
REQ-014 mem_req  output  1  request to the single-port memory.
REQ-015 mem_we  output  1  memory write enable.
REQ-016 mem_addr  output  32  memory address.
REQ-017 mem_wdata  output  32  memory write data.
REQ-018 mem_rdata  input  32  memory read data, valid when mem_ready=1.
REQ-019 mem_ready  input  1  memory completes the current access this cycle.
REQ-020 stall  output  1  combinational: (if_req & ~if_ack) | (dm_req & ~dm_ack); freezes the pipeline registers.

Function
REQ-021 The FSM SHALL have exactly three states, IDLE, BUSY_IF and BUSY_DM, with IDLE entered at reset.
REQ-022 In IDLE, an eligible requester SHALL be granted on the next clock edge: the state moves to BUSY_IF or BUSY_DM, and mem_we, mem_addr and mem_wdata latch the granted requester's values (mem_we=0 and mem_wdata unchanged for a fetch).
REQ-023 A requester SHALL be ineligible in a cycle where its own ack is high, so that a held req is not re-granted.
REQ-024 When both requesters are eligible, data SHALL win unless dm_streak equals MAX_DM_BURST, in which case fetch wins.
REQ-025 dm_streak SHALL increment (saturating at MAX_DM_BURST) on a data grant made while if_req=1, SHALL clear on any fetch grant, and SHALL clear on a data grant made while if_req=0.
REQ-026 mem_req SHALL be 1 exactly while in BUSY_IF or BUSY_DM, and mem_addr, mem_we and mem_wdata SHALL stay stable throughout, regardless of requester input changes.
REQ-027 In a BUSY state with mem_ready=0, the state SHALL hold, with no timeout.
REQ-028 In BUSY_IF with mem_ready=1, the next edge SHALL go to IDLE, set if_ack=1 for one cycle, and load if_rdata<=mem_rdata.
REQ-029 In BUSY_DM with mem_ready=1, the next edge SHALL go to IDLE and set dm_ack=1 for one cycle; dm_rdata<=mem_rdata only when the latched mem_we=0, and dm_rdata SHALL be unchanged on a store.
REQ-030 Minimum latency SHALL be 2 cycles from req to ack (grant edge, then mem_ready on the first BUSY cycle); back-to-back throughput SHALL be one access per 3 cycles (IDLE turnaround).
REQ-031 A req deasserted while not granted SHALL be dropped silently; a req deasserted after grant SHALL still be completed and acked.
REQ-032 mem_ready asserted in IDLE SHALL be ignored.

Reset
REQ-033 Asserting reset SHALL immediately force state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ack=0, dm_ack=0, if_rdata=0, dm_rdata=0 and dm_streak=0.
REQ-034 Reset mid-transaction SHALL abandon the access, with no ack issued; after release the first grant SHALL follow normal arbitration.

Verification
REQ-035 Single fetch: if_req=1, if_addr=0x100, mem_ready=1 on the first BUSY cycle with mem_rdata=0x00500093 -> mem_addr=0x100 and mem_we=0; if_ack pulses 2 cycles after req; if_rdata=0x00500093.
REQ-036 Store then load: dm store to addr 0x40 with wdata 0xDEADBEEF -> mem_we=1 and dm_rdata unchanged; then a load from 0x40 returning 0xDEADBEEF -> dm_rdata=0xDEADBEEF.
REQ-037 Contention: if_req and dm_req both held continuously, memory always ready -> grant order D,D,D,D,F,D,D,D,D,F.
REQ-038 Wait states: mem_ready low for 5 BUSY cycles -> mem_req and mem_addr stable for 6 cycles, stall=1 throughout, exactly one ack.
REQ-039 Reset mid-op: reset asserted in BUSY_DM -> mem_req=0 in the same cycle; no dm_ack; all outputs zero; a held dm_req is re-granted after release.
REQ-040 Held req after ack: dm_req kept high in the ack cycle while if_req=1 -> the fetch is granted next, with no duplicate data access.
